alu_issue_ctrl: RTL and testbench

//  Issue side of the 32-bit ALU. Accepts one decoded RV32 integer instruction per handshake,

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_op_decode.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 119 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, decoded opcodes and issue FSM state encoding.
// Imported by alu_op_decode and alu_issue_ctrl.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32 R/I decode to ALU control code; latency 0, no flow control.
// Unsupported encodings flag illegal and fall back to ADD of the selected operands.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control,
  output logic       use_imm,
  output logic       is_shift,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    use_imm     = (opcode == OPC_OP_IMM);
    is_shift    = 1'b0;
    illegal     = 1'b0;
    if ((opcode != OPC_OP) && (opcode != OPC_OP_IMM)) begin
      illegal = 1'b1;
    end else begin
      case (funct3)
        3'b000: if ((opcode == OPC_OP) && funct7_5) alu_control = ALU_SUB;
        3'b111: alu_control = ALU_AND;
        3'b110: alu_control = ALU_OR;
        3'b001: begin
          alu_control = ALU_SLL;
          is_shift    = 1'b1;
        end
        // funct7_5 set here is SRA, which this ALU does not implement
        3'b101: begin
          if (!funct7_5) begin
            alu_control = ALU_SRL;
            is_shift    = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/capture stage: IDLE->EXEC->DONE, result valid one edge after EXEC (1 op / 3 cycles).
// Holds result until out_ready; in_ready only in IDLE. ALU_ILLEGAL_TRAP_EN zeroes illegal results.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [2:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t          state, state_nxt;
  logic            run;
  logic            accept, capture;
  logic [2:0]      dec_control;
  logic            dec_use_imm, dec_is_shift, dec_illegal;
  logic            illegal_q;
  logic [XLEN-1:0] operand2, in2_nxt;

  alu_op_decode u_dec (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (dec_control),
    .use_imm     (dec_use_imm),
    .is_shift    (dec_is_shift),
    .illegal     (dec_illegal)
  );

  assign operand2 = dec_use_imm ? imm : rs2_data;
  assign in2_nxt  = dec_is_shift ? {{(XLEN-SHAMT_W){1'b0}}, operand2[SHAMT_W-1:0]} : operand2;

  // Keeps in_ready low while reset is asserted and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = run;
        if (in_valid && run) begin
          accept    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        capture   = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_control <= '0;
      out_rd      <= '0;
      illegal_q   <= 1'b0;
      out_result  <= '0;
    end else begin
      if (accept) begin
        alu_in1     <= rs1_data;
        alu_in2     <= in2_nxt;
        alu_control <= dec_control;
        out_rd      <= rd;
        illegal_q   <= dec_illegal;
      end
      if (capture) begin
        out_result <= (illegal_q && TRAP_EN) ? '0 : alu_result;
      end
    end
  end

  assign out_illegal = illegal_q & TRAP_EN;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, random ops vs. a reference model,
// backpressure and mid-transaction reset sequences. Honours ALU_ILLEGAL_TRAP_EN.
module tb_alu_issue_ctrl;

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rd;
  logic [31:0] alu_in1, alu_in2;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .rd          (rd),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The combinational ALU that sits downstream of the issue stage.
  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      3'b000: alu_result = alu_in1 & alu_in2;
      3'b001: alu_result = alu_in1 | alu_in2;
      3'b010: alu_result = alu_in1 << alu_in2[4:0];
      3'b011: alu_result = alu_in1 >> alu_in2[4:0];
      3'b100: alu_result = alu_in1 - alu_in2;
      3'b101: alu_result = alu_in1 + alu_in2;
      default: alu_result = 32'h0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: RV32 semantics of the supported subset, written per mnemonic.
  function automatic void model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                                output logic [2:0] ctl, output logic [31:0] in2,
                                output logic [31:0] res, output logic ill);
    bit is_r = (opc == 7'h33);
    bit is_i = (opc == 7'h13);
    logic [31:0] op2 = is_i ? im : b;
    int sh = op2 % 32;
    ill = !(is_r || is_i) || (f3 == 3'd2) || (f3 == 3'd3) || (f3 == 3'd4) || (f3 == 3'd5 && f7);
    ctl = 3'd5; in2 = op2; res = a + op2;
    if (ill) begin
      if (TRAP) res = 32'h0;
      ill = TRAP;
      return;
    end
    if (f3 == 3'd0 && is_r && f7) begin ctl = 3'd4; res = a - op2; end
    else if (f3 == 3'd7) begin ctl = 3'd0; res = a & op2; end
    else if (f3 == 3'd6) begin ctl = 3'd1; res = a | op2; end
    else if (f3 == 3'd1) begin ctl = 3'd2; in2 = sh; res = a << sh; end
    else if (f3 == 3'd5) begin ctl = 3'd3; in2 = sh; res = a >> sh; end
  endfunction

  task automatic run_op(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [4:0] d, input logic [2:0] e_ctl,
                        input logic [31:0] e_in2, input logic [31:0] e_res, input logic e_ill,
                        input bit chk_dec, input int hold);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk({nm, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    opcode = opc; funct3 = f3; funct7_5 = f7;
    rs1_data = a; rs2_data = b; imm = im; rd = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_alu_in1"}, alu_in1, a);
    if (chk_dec) begin
      chk({nm, "_alu_control"}, 32'(alu_control), 32'(e_ctl));
      chk({nm, "_alu_in2"}, alu_in2, e_in2);
    end
    chk({nm, "_exec_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_exec_in_ready"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_out_result"}, out_result, e_res);
    chk({nm, "_out_rd"}, 32'(out_rd), 32'(d));
    chk({nm, "_out_illegal"}, 32'(out_illegal), 32'(e_ill));
    // Upstream keeps offering while the result is stalled; nothing may be accepted.
    if (hold > 0) in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_out_result"}, out_result, e_res);
      chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({nm, "_hold_alu_in1"}, alu_in1, a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_release_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    string       nm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a, b, im;
    logic [4:0]  d;
    logic [2:0]  e_ctl;
    logic [31:0] e_in2, e_res;
    logic        e_ill;
    int          hold;
  } vec_t;

  task automatic chk_all_zero(input string nm);
    chk({nm, "_alu_in1"}, alu_in1, 32'h0);
    chk({nm, "_alu_in2"}, alu_in2, 32'h0);
    chk({nm, "_alu_control"}, 32'(alu_control), 32'h0);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({nm, "_out_result"}, out_result, 32'h0);
    chk({nm, "_out_rd"}, 32'(out_rd), 32'h0);
    chk({nm, "_out_illegal"}, 32'(out_illegal), 32'h0);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'h0);
  endtask

  initial begin
    vec_t vecs[11];
    logic [2:0]  m_ctl;
    logic [31:0] m_in2, m_res;
    logic        m_ill;
    logic [6:0]  r_opc;
    logic [2:0]  r_f3;
    logic        r_f7;
    logic [31:0] r_a, r_b, r_im;
    logic [4:0]  r_d;

    vecs[0]  = '{"add_ovf", 7'h33, 3'd0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd3,
                 3'b101, 32'h1, 32'h80000000, 1'b0, 4};
    vecs[1]  = '{"sub", 7'h33, 3'd0, 1'b1, 32'h5, 32'h7, 32'h0, 5'd4,
                 3'b100, 32'h7, 32'hFFFFFFFE, 1'b0, 0};
    vecs[2]  = '{"slli", 7'h13, 3'd1, 1'b0, 32'h1, 32'hDEAD, 32'h25, 5'd5,
                 3'b010, 32'h5, 32'h20, 1'b0, 0};
    vecs[3]  = '{"srl", 7'h33, 3'd5, 1'b0, 32'h80000000, 32'd31, 32'h0, 5'd6,
                 3'b011, 32'h1F, 32'h1, 1'b0, 1};
    vecs[4]  = '{"xor", 7'h33, 3'd4, 1'b0, 32'h3, 32'h5, 32'h0, 5'd7,
                 3'b101, 32'h5, TRAP ? 32'h0 : 32'h8, TRAP, 0};
    vecs[5]  = '{"and", 7'h33, 3'd7, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 5'd8,
                 3'b000, 32'hFF00, 32'hF000, 1'b0, 0};
    vecs[6]  = '{"ori", 7'h13, 3'd6, 1'b0, 32'h100, 32'h0, 32'hFFFFFFF0, 5'd9,
                 3'b001, 32'hFFFFFFF0, 32'hFFFFFFF0, 1'b0, 0};
    vecs[7]  = '{"addi_neg", 7'h13, 3'd0, 1'b1, 32'd10, 32'h0, 32'hFFFFFFFF, 5'd10,
                 3'b101, 32'hFFFFFFFF, 32'd9, 1'b0, 0};
    vecs[8]  = '{"sra", 7'h33, 3'd5, 1'b1, 32'h80000000, 32'h4, 32'h0, 5'd11,
                 3'b101, 32'h4, TRAP ? 32'h0 : 32'h80000004, TRAP, 2};
    vecs[9]  = '{"bad_opc", 7'h03, 3'd0, 1'b0, 32'h2, 32'h3, 32'h100, 5'd12,
                 3'b101, 32'h3, TRAP ? 32'h0 : 32'h5, TRAP, 0};
    vecs[10] = '{"sll_wide", 7'h33, 3'd1, 1'b0, 32'h3, 32'h21, 32'h0, 5'd31,
                 3'b010, 32'h1, 32'h6, 1'b0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; rd = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].nm, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b,
             vecs[i].im, vecs[i].d, vecs[i].e_ctl, vecs[i].e_in2, vecs[i].e_res,
             vecs[i].e_ill, !(TRAP && vecs[i].e_ill), vecs[i].hold);
    end

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    r_opc = 7'h33;
        2, 3:    r_opc = 7'h13;
        default: r_opc = 7'($urandom);
      endcase
      r_f3 = 3'($urandom);
      r_f7 = 1'($urandom);
      r_a  = $urandom;
      r_b  = $urandom;
      r_im = $urandom_range(0, 1) ? $urandom : 32'($signed(12'($urandom)));
      r_d  = 5'($urandom);
      model(r_opc, r_f3, r_f7, r_a, r_b, r_im, m_ctl, m_in2, m_res, m_ill);
      run_op("rand", r_opc, r_f3, r_f7, r_a, r_b, r_im, r_d, m_ctl, m_in2, m_res, m_ill,
             !(TRAP && m_ill), int'($urandom_range(0, 2)));
    end

    // Reset asserted while the operation is in EXEC.
    opcode = 7'h33; funct3 = 3'd0; funct7_5 = 1'b0;
    rs1_data = 32'h1234; rs2_data = 32'h1111; imm = 32'h0; rd = 5'd21;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_exec_precheck_alu_in1", alu_in1, 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_exec");
    @(posedge clk); #1;
    chk_all_zero("rst_exec_held");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exec_in_ready", 32'(in_ready), 32'd1);
    chk("rst_exec_no_stale_valid", 32'(out_valid), 32'd0);
    chk("rst_exec_out_result", out_result, 32'h0);

    run_op("after_rst", 7'h33, 3'd0, 1'b0, 32'h10, 32'h20, 32'h0, 5'd2,
           3'b101, 32'h20, 32'h30, 1'b0, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
